// File: rtl/load_store_queue.sv
// load_store_queue
//   In-order memory-op queue that sits between dispatch/AGU and the data cache.
//   Ops enter in program order, collect address/data from the AGU, and leave
//   from the head one at a time: stores once committed by the ROB, loads as
//   soon as their address is known. Load results are captured one cycle after
//   the cache read, extended to 32 bits and broadcast with their ROB tag.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   alloc_*             dispatch allocation (type, size, signedness, tag);
//                       alloc_ready is low while the queue is full
//   agu_*               address/store-data result tagged by ROB tag
//   commit_valid/tag    ROB retiring a store
//   flush               squash every entry
//   mem_*               registered cache request, mem_rdata/mem_miss response
//   ld_done_*           one-cycle load completion broadcast
//   count               occupied entries (0..DEPTH)
module load_store_queue #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic                     alloc_is_store,
    input  logic                     alloc_size,
    input  logic                     alloc_unsigned,
    input  logic [TAG_W-1:0]         alloc_tag,
    output logic                     alloc_ready,
    input  logic                     agu_valid,
    input  logic [TAG_W-1:0]         agu_tag,
    input  logic [31:0]              agu_addr,
    input  logic [31:0]              agu_data,
    input  logic                     commit_valid,
    input  logic [TAG_W-1:0]         commit_tag,
    input  logic                     flush,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     mem_size,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_miss,
    output logic                     ld_done_valid,
    output logic [TAG_W-1:0]         ld_done_tag,
    output logic [31:0]              ld_done_data,
    output logic                     ld_done_miss,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_store;
    logic [DEPTH-1:0] ent_size;
    logic [DEPTH-1:0] ent_unsigned;
    logic [DEPTH-1:0] ent_addr_rdy;
    logic [DEPTH-1:0] ent_committed;
    logic [TAG_W-1:0] ent_tag  [DEPTH];
    logic [31:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [0:0]       state;

    logic             do_alloc;
    logic             head_ready;
    logic             issue_load;
    logic             issue_store;
    logic             load_done;
    logic             do_deq;
    logic [DEPTH-1:0] agu_hit;
    logic [DEPTH-1:0] commit_hit;
    logic [31:0]      ext_data;

    assign alloc_ready = (count != FULL_COUNT);

    // Issue/dequeue decisions. LOAD_WAIT spans two cycles: the cycle with
    // mem_read high, then the cycle in which the cache response is sampled;
    // mem_read itself tells the two apart.
    always_comb begin
        do_alloc    = alloc_valid && alloc_ready;
        head_ready  = ent_valid[head] && ent_addr_rdy[head];
        issue_load  = (state == ST_IDLE) && head_ready && !ent_store[head];
        issue_store = (state == ST_IDLE) && head_ready && ent_store[head]
                      && ent_committed[head];
        load_done   = (state == ST_LOAD_WAIT) && !mem_read;
        do_deq      = issue_store || load_done;
    end

    // Tag matches only look at entries valid before this edge, so an entry
    // allocated in the same cycle can never be hit.
    always_comb begin
        agu_hit    = '0;
        commit_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            agu_hit[i]    = agu_valid && ent_valid[i] && (ent_tag[i] == agu_tag);
            commit_hit[i] = commit_valid && ent_valid[i] && ent_store[i]
                            && (ent_tag[i] == commit_tag);
        end
    end

    // Load result extension; a miss returns zero regardless of size.
    always_comb begin
        ext_data = '0;
        if (!mem_miss) begin
            if (ent_size[head])
                ext_data = {{24{~ent_unsigned[head] & mem_rdata[7]}}, mem_rdata[7:0]};
            else
                ext_data = {{16{~ent_unsigned[head] & mem_rdata[15]}}, mem_rdata[15:0]};
        end
    end

    // Entry payload needs no reset: it is only read while the entry is valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (agu_hit[i]) begin
                    ent_addr[i] <= agu_addr;
                    ent_data[i] <= agu_data;
                end
            end
            if (do_alloc) begin
                ent_tag[tail]      <= alloc_tag;
                ent_store[tail]    <= alloc_is_store;
                ent_size[tail]     <= alloc_size;
                ent_unsigned[tail] <= alloc_unsigned;
            end
        end
    end

    // Queue control, FSM and registered cache/broadcast outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid     <= '0;
            ent_addr_rdy  <= '0;
            ent_committed <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            state         <= ST_IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_size      <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            ld_done_valid <= 1'b0;
            ld_done_tag   <= '0;
            ld_done_data  <= '0;
            ld_done_miss  <= 1'b0;
        end else if (flush) begin
            ent_valid     <= '0;
            ent_addr_rdy  <= '0;
            ent_committed <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            state         <= ST_IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            ld_done_valid <= 1'b0;
        end else begin
            ent_addr_rdy  <= ent_addr_rdy | agu_hit;
            ent_committed <= ent_committed | commit_hit;
            mem_write     <= issue_store;
            ld_done_valid <= load_done;

            if (do_deq) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (do_alloc) begin
                ent_valid[tail]     <= 1'b1;
                ent_addr_rdy[tail]  <= 1'b0;
                ent_committed[tail] <= 1'b0;
                tail                <= tail + 1'b1;
            end

            case ({do_alloc, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (issue_load) begin
                        mem_read <= 1'b1;
                        mem_addr <= ent_addr[head];
                        mem_size <= ent_size[head];
                        state    <= ST_LOAD_WAIT;
                    end else if (issue_store) begin
                        mem_addr  <= ent_addr[head];
                        mem_size  <= ent_size[head];
                        mem_wdata <= ent_data[head];
                    end
                end
                default: begin
                    if (mem_read) begin
                        mem_read <= 1'b0;
                    end else begin
                        ld_done_tag  <= ent_tag[head];
                        ld_done_data <= ext_data;
                        ld_done_miss <= mem_miss;
                        state        <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_queue.sv
// tb_load_store_queue
//   Directed scenarios for reset, full/wrap, store-then-load, miss, ordering
//   and flush, followed by a randomized run compared cycle by cycle against a
//   queue-based reference model.
module tb_load_store_queue;

    localparam int DEPTH = 16;
    localparam int TAG_W = 6;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alloc_valid = 1'b0;
    logic             alloc_is_store = 1'b0;
    logic             alloc_size = 1'b0;
    logic             alloc_unsigned = 1'b0;
    logic [TAG_W-1:0] alloc_tag = '0;
    logic             alloc_ready;
    logic             agu_valid = 1'b0;
    logic [TAG_W-1:0] agu_tag = '0;
    logic [31:0]      agu_addr = '0;
    logic [31:0]      agu_data = '0;
    logic             commit_valid = 1'b0;
    logic [TAG_W-1:0] commit_tag = '0;
    logic             flush = 1'b0;
    logic             mem_read;
    logic             mem_write;
    logic             mem_size;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = JUNK;
    logic             mem_miss = 1'b1;
    logic             ld_done_valid;
    logic [TAG_W-1:0] ld_done_tag;
    logic [31:0]      ld_done_data;
    logic             ld_done_miss;
    logic [4:0]       count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        is_store;
        bit        size;
        bit        uns;
        bit [5:0]  tag;
        bit        addr_rdy;
        bit        committed;
        bit [31:0] addr;
        bit [31:0] data;
    } op_t;

    load_store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
        .alloc_size(alloc_size), .alloc_unsigned(alloc_unsigned),
        .alloc_tag(alloc_tag), .alloc_ready(alloc_ready),
        .agu_valid(agu_valid), .agu_tag(agu_tag), .agu_addr(agu_addr), .agu_data(agu_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_miss(mem_miss),
        .ld_done_valid(ld_done_valid), .ld_done_tag(ld_done_tag),
        .ld_done_data(ld_done_data), .ld_done_miss(ld_done_miss),
        .count(count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extension rule written arithmetically: keep the low bits, subtract
    // 2^width when signed and the value is in the upper half.
    function automatic logic [31:0] extend(logic [31:0] raw, bit is_byte, bit uns, bit miss);
        int unsigned width;
        int unsigned v;
        if (miss) return 32'd0;
        width = is_byte ? 8 : 16;
        v = raw % (32'd1 << width);
        if (!uns && v >= (32'd1 << (width - 1))) v = v - (32'd1 << width);
        return v;
    endfunction

    task automatic alloc_op(bit st, bit sz, bit uns, logic [TAG_W-1:0] t);
        alloc_valid = 1'b1; alloc_is_store = st; alloc_size = sz;
        alloc_unsigned = uns; alloc_tag = t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem: got rd=%b wr=%b expected 0 0", mem_read, mem_write); end
        checks++; if (ld_done_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_done: got %b expected 0", ld_done_valid); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_op(1'b0, 1'b1, 1'b1, TAG_W'(i));
            tick();
        end
        checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL full_count: got %0d expected 16", count); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_alloc_ready: got %b expected 0", alloc_ready); end
        alloc_op(1'b0, 1'b1, 1'b1, 6'd16);
        tick();
        alloc_valid = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL overfill_count: got %0d expected 16", count); end
        agu_valid = 1'b1; agu_tag = 6'd0; agu_addr = 32'h100; agu_data = 32'h0;
        tick();
        agu_valid = 1'b0;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL wrap_issue: got rd=%b addr=%h expected 1 00000100", mem_read, mem_addr); end
        tick();
        mem_rdata = 32'h0000_0055; mem_miss = 1'b0;
        tick();
        mem_rdata = JUNK; mem_miss = 1'b1;
        checks++; if (ld_done_valid !== 1'b1 || ld_done_tag !== 6'd0 || ld_done_data !== 32'h55) begin errors++; $display("[TB] FAIL wrap_ld_done: got v=%b tag=%0d data=%h expected 1 0 00000055", ld_done_valid, ld_done_tag, ld_done_data); end
        checks++; if (count !== 5'd15 || alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL wrap_dequeue: got count=%0d ready=%b expected 15 1", count, alloc_ready); end
        alloc_op(1'b0, 1'b1, 1'b1, 6'd20);
        tick();
        alloc_valid = 1'b0;
        checks++; if (count !== 5'd16 || alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL wrap_refill: got count=%0d ready=%b expected 16 0", count, alloc_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL wrap_flush_count: got %0d expected 0", count); end
    endtask

    task automatic test_store_load();
        alloc_op(1'b1, 1'b0, 1'b0, 6'd3);
        tick();
        alloc_op(1'b0, 1'b0, 1'b0, 6'd4);
        agu_valid = 1'b1; agu_tag = 6'd3; agu_addr = 32'h0000_2040; agu_data = 32'h1234;
        tick();
        alloc_valid = 1'b0;
        agu_tag = 6'd4; agu_data = 32'h0;
        commit_valid = 1'b1; commit_tag = 6'd3;
        tick();
        agu_valid = 1'b0; commit_valid = 1'b0;
        tick();
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h2040 || mem_wdata !== 32'h1234 || mem_size !== 1'b0) begin
            errors++; $display("[TB] FAIL store_issue: got wr=%b rd=%b addr=%h wdata=%h size=%b expected 1 0 00002040 00001234 0", mem_write, mem_read, mem_addr, mem_wdata, mem_size); end
        tick();
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 32'h2040 || mem_size !== 1'b0) begin
            errors++; $display("[TB] FAIL load_issue: got wr=%b rd=%b addr=%h size=%b expected 0 1 00002040 0", mem_write, mem_read, mem_addr, mem_size); end
        tick();
        mem_rdata = 32'h0000_8234; mem_miss = 1'b0;
        checks++; if (mem_read !== 1'b0 || ld_done_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_wait: got rd=%b done=%b expected 0 0", mem_read, ld_done_valid); end
        tick();
        mem_rdata = JUNK; mem_miss = 1'b1;
        checks++; if (ld_done_valid !== 1'b1 || ld_done_tag !== 6'd4 || ld_done_data !== 32'hFFFF_8234 || ld_done_miss !== 1'b0) begin
            errors++; $display("[TB] FAIL load_result: got v=%b tag=%0d data=%h miss=%b expected 1 4 ffff8234 0", ld_done_valid, ld_done_tag, ld_done_data, ld_done_miss); end
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL store_load_count: got %0d expected 0", count); end
        tick();
        checks++; if (ld_done_valid !== 1'b0) begin errors++; $display("[TB] FAIL ld_done_pulse: got %b expected 0", ld_done_valid); end
    endtask

    task automatic test_miss();
        alloc_op(1'b0, 1'b1, 1'b1, 6'd7);
        tick();
        alloc_valid = 1'b0;
        agu_valid = 1'b1; agu_tag = 6'd7; agu_addr = 32'h33;
        tick();
        agu_valid = 1'b0;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_size !== 1'b1 || mem_addr !== 32'h33) begin errors++; $display("[TB] FAIL miss_issue: got rd=%b size=%b addr=%h expected 1 1 00000033", mem_read, mem_size, mem_addr); end
        tick();
        mem_rdata = 32'h0000_00F0; mem_miss = 1'b1;
        tick();
        mem_rdata = JUNK;
        checks++; if (ld_done_valid !== 1'b1 || ld_done_miss !== 1'b1 || ld_done_data !== 32'h0 || ld_done_tag !== 6'd7) begin
            errors++; $display("[TB] FAIL miss_result: got v=%b miss=%b data=%h tag=%0d expected 1 1 00000000 7", ld_done_valid, ld_done_miss, ld_done_data, ld_done_tag); end
    endtask

    task automatic test_in_order();
        alloc_op(1'b1, 1'b0, 1'b0, 6'd10);
        tick();
        alloc_op(1'b0, 1'b0, 1'b1, 6'd11);
        agu_valid = 1'b1; agu_tag = 6'd10; agu_addr = 32'h500; agu_data = 32'hABCD;
        tick();
        alloc_valid = 1'b0;
        agu_tag = 6'd11; agu_addr = 32'h600;
        tick();
        agu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("[TB] FAIL uncommitted_block: got rd=%b wr=%b expected 0 0", mem_read, mem_write); end
        end
        commit_valid = 1'b1; commit_tag = 6'd10;
        tick();
        commit_valid = 1'b0;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL commit_early: got wr=%b expected 0", mem_write); end
        tick();
        checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h500 || mem_wdata !== 32'hABCD) begin errors++; $display("[TB] FAIL order_store: got wr=%b addr=%h wdata=%h expected 1 00000500 0000abcd", mem_write, mem_addr, mem_wdata); end
        tick();
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h600) begin errors++; $display("[TB] FAIL order_load: got rd=%b wr=%b addr=%h expected 1 0 00000600", mem_read, mem_write, mem_addr); end
        tick();
        mem_rdata = 32'h0001_F00D; mem_miss = 1'b0;
        tick();
        mem_rdata = JUNK; mem_miss = 1'b1;
        checks++; if (ld_done_valid !== 1'b1 || ld_done_tag !== 6'd11 || ld_done_data !== 32'h0000_F00D) begin errors++; $display("[TB] FAIL order_result: got v=%b tag=%0d data=%h expected 1 11 0000f00d", ld_done_valid, ld_done_tag, ld_done_data); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            alloc_op(1'b0, 1'b0, 1'b0, TAG_W'(20 + i));
            tick();
        end
        alloc_valid = 1'b0;
        agu_valid = 1'b1; agu_tag = 6'd20; agu_addr = 32'h40;
        tick();
        agu_valid = 1'b0;
        tick();
        checks++; if (mem_read !== 1'b1 || count !== 5'd5) begin errors++; $display("[TB] FAIL flush_setup: got rd=%b count=%0d expected 1 5", mem_read, count); end
        flush = 1'b1;
        alloc_op(1'b0, 1'b0, 1'b0, 6'd40);
        tick();
        flush = 1'b0; alloc_valid = 1'b0;
        checks++; if (mem_read !== 1'b0 || count !== 5'd0 || ld_done_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_clear: got rd=%b count=%0d done=%b expected 0 0 0", mem_read, count, ld_done_valid); end
        tick();
        checks++; if (ld_done_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_dropped_load: got %b expected 0", ld_done_valid); end
        alloc_op(1'b0, 1'b1, 1'b0, 6'd30);
        tick();
        alloc_valid = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL flush_realloc: got %0d expected 1", count); end
        agu_valid = 1'b1; agu_tag = 6'd30; agu_addr = 32'h44;
        tick();
        agu_valid = 1'b0;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h44) begin errors++; $display("[TB] FAIL flush_new_head: got rd=%b addr=%h expected 1 00000044", mem_read, mem_addr); end
        tick();
        mem_rdata = 32'h0000_0080; mem_miss = 1'b0;
        tick();
        mem_rdata = JUNK; mem_miss = 1'b1;
        checks++; if (ld_done_valid !== 1'b1 || ld_done_tag !== 6'd30 || ld_done_data !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL signed_byte: got v=%b tag=%0d data=%h expected 1 30 ffffff80", ld_done_valid, ld_done_tag, ld_done_data); end
    endtask

    task automatic test_random();
        op_t q[$];
        op_t n;
        int lphase = 0;
        bit deq;
        bit accept;
        logic [5:0] next_tag = 6'd0;
        logic e_rd = 1'b0, e_wr = 1'b0, e_size = 1'b0, e_done = 1'b0, e_miss = 1'b0;
        logic [31:0] e_addr = '0, e_wdata = '0, e_data = '0;
        logic [5:0] e_tag = '0;

        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush          = ($urandom_range(0, 99) == 0);
            alloc_valid    = ($urandom_range(0, 99) < 55);
            alloc_is_store = $urandom_range(0, 1);
            alloc_size     = $urandom_range(0, 1);
            alloc_unsigned = $urandom_range(0, 1);
            alloc_tag      = next_tag;
            agu_valid      = ($urandom_range(0, 99) < 50);
            agu_addr       = $urandom;
            agu_data       = $urandom;
            if (q.size() > 0 && $urandom_range(0, 3) != 0) agu_tag = q[$urandom_range(0, q.size() - 1)].tag;
            else agu_tag = TAG_W'($urandom);
            commit_valid   = ($urandom_range(0, 99) < 30);
            if (q.size() > 0) commit_tag = q[$urandom_range(0, q.size() - 1)].tag;
            else commit_tag = TAG_W'($urandom);
            mem_rdata      = $urandom;
            mem_miss       = ($urandom_range(0, 3) == 0);

            accept = alloc_valid && (q.size() < DEPTH);
            if (flush) begin
                q.delete();
                lphase = 0; e_rd = 1'b0; e_wr = 1'b0; e_done = 1'b0;
            end else begin
                deq = 1'b0; e_wr = 1'b0; e_done = 1'b0; e_rd = 1'b0;
                if (lphase == 1) begin
                    lphase = 2;
                end else if (lphase == 2) begin
                    e_done = 1'b1; e_tag = q[0].tag; e_miss = mem_miss;
                    e_data = extend(mem_rdata, q[0].size, q[0].uns, mem_miss);
                    deq = 1'b1; lphase = 0;
                end else if (q.size() > 0 && q[0].addr_rdy) begin
                    if (!q[0].is_store) begin
                        e_rd = 1'b1; e_addr = q[0].addr; e_size = q[0].size; lphase = 1;
                    end else if (q[0].committed) begin
                        e_wr = 1'b1; e_addr = q[0].addr; e_size = q[0].size;
                        e_wdata = q[0].data; deq = 1'b1;
                    end
                end
                foreach (q[i]) begin
                    if (agu_valid && q[i].tag == agu_tag) begin
                        q[i].addr = agu_addr; q[i].data = agu_data; q[i].addr_rdy = 1'b1;
                    end
                    if (commit_valid && q[i].is_store && q[i].tag == commit_tag) q[i].committed = 1'b1;
                end
                if (deq) q.delete(0);
                if (accept) begin
                    n.is_store = alloc_is_store; n.size = alloc_size; n.uns = alloc_unsigned;
                    n.tag = alloc_tag; n.addr_rdy = 1'b0; n.committed = 1'b0;
                    n.addr = '0; n.data = '0;
                    q.push_back(n);
                    next_tag = next_tag + 6'd1;
                end
            end

            tick();
            checks++; if (mem_read !== e_rd || mem_write !== e_wr) begin errors++; $display("[TB] FAIL rnd_mem_ctl cyc %0d: got rd=%b wr=%b expected %b %b", cyc, mem_read, mem_write, e_rd, e_wr); end
            if (e_rd || e_wr) begin
                checks++; if (mem_addr !== e_addr || mem_size !== e_size) begin errors++; $display("[TB] FAIL rnd_mem_addr cyc %0d: got addr=%h size=%b expected %h %b", cyc, mem_addr, mem_size, e_addr, e_size); end
            end
            if (e_wr) begin
                checks++; if (mem_wdata !== e_wdata) begin errors++; $display("[TB] FAIL rnd_wdata cyc %0d: got %h expected %h", cyc, mem_wdata, e_wdata); end
            end
            checks++; if (ld_done_valid !== e_done) begin errors++; $display("[TB] FAIL rnd_ld_valid cyc %0d: got %b expected %b", cyc, ld_done_valid, e_done); end
            if (e_done) begin
                checks++; if (ld_done_tag !== e_tag || ld_done_data !== e_data || ld_done_miss !== e_miss) begin
                    errors++; $display("[TB] FAIL rnd_ld_result cyc %0d: got tag=%0d data=%h miss=%b expected %0d %h %b", cyc, ld_done_tag, ld_done_data, ld_done_miss, e_tag, e_data, e_miss); end
            end
            checks++; if (count !== 5'(q.size()) || alloc_ready !== (q.size() != DEPTH)) begin
                errors++; $display("[TB] FAIL rnd_count cyc %0d: got count=%0d ready=%b expected %0d %b", cyc, count, alloc_ready, q.size(), (q.size() != DEPTH)); end
        end
        alloc_valid = 1'b0; agu_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_full_wrap();
        test_store_load();
        test_miss();
        test_in_order();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
